// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART baud engine: legal oversample
// ratios, the {int,frac} divisor word and the reset-divisor calculation.
package uart_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int FRAC_W_DEF = 8;

  localparam int OVS_8  = 8;
  localparam int OVS_16 = 16;

  typedef struct packed {
    logic [DIV_W_DEF-1:0]  int_part;
    logic [FRAC_W_DEF-1:0] frac_part;
  } div_word_t;

  function automatic bit ovs_legal(input int ovs);
    return (ovs == OVS_8) || (ovs == OVS_16);
  endfunction

  // Integer part is whole clocks per oversample tick; fractional part is the
  // truncated remainder in units of 1/2^FRAC_W clock.
  function automatic div_word_t calc_div(input longint sys_clk, input longint baud,
                                         input longint ovs);
    longint    den;
    longint    quo;
    longint    rem;
    div_word_t d;
    den         = baud * ovs;
    quo         = sys_clk / den;
    rem         = sys_clk % den;
    d.int_part  = DIV_W_DEF'(quo);
    d.frac_part = FRAC_W_DEF'((rem << FRAC_W_DEF) / den);
    return d;
  endfunction

endpackage

// File: rtl/uart_baud_engine_if.sv
// Control/status bundle between a UART block and its baud engine.
interface uart_baud_engine_if
  import uart_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
);
  logic                    baud_en;
  logic                    div_load;
  logic [DIV_W-1:0]        div_int;
  logic [FRAC_W-1:0]       div_frac;
  logic                    resync;
  logic                    rx_tick;
  logic                    mid_tick;
  logic                    tx_tick;
  logic [DIV_W+FRAC_W-1:0] div_active;

  modport master (
    output baud_en, div_load, div_int, div_frac, resync,
    input  rx_tick, mid_tick, tx_tick, div_active
  );

  modport slave (
    input  baud_en, div_load, div_int, div_frac, resync,
    output rx_tick, mid_tick, tx_tick, div_active
  );
endinterface

// File: rtl/uart_frac_accum.sv
// Fractional phase accumulator: flags the periods that need one extra clock
// so the long-run mean period is int + frac/2^FRAC_W.
module uart_frac_accum #(
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              clear,
  input  logic [FRAC_W-1:0] frac,
  output logic              ext
);
  logic [FRAC_W-1:0] frac_acc;
  logic [FRAC_W:0]   sum;

  // Carry out of acc+frac stretches the current period by one clock
  always_comb begin
    sum = {1'b0, frac_acc} + {1'b0, frac};
    ext = sum[FRAC_W];
  end

  // Accumulate once per completed period; resync restarts the phase
  always_ff @(posedge clk) begin
    if (!rst) begin
      frac_acc <= '0;
    end else if (clear) begin
      frac_acc <= '0;
    end else if (step) begin
      frac_acc <= sum[FRAC_W-1:0];
    end
  end
endmodule

// File: rtl/uart_baud_engine.sv
// Programmable fractional baud-tick generator: oversample tick, mid-bit
// strobe and bit-rate tick, with shadowed divisor loads and phase resync.
module uart_baud_engine
  import uart_pkg::*;
#(
  parameter int SYS_CLK    = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int FRAC_W     = FRAC_W_DEF
) (
  input logic                clk,
  input logic                rst,
  uart_baud_engine_if.slave  bus
);
  // Illegal ratios fall back to 16 so the counters stay power-of-two sized
  localparam int OVS  = ovs_legal(OVERSAMPLE) ? OVERSAMPLE : OVS_16;
  localparam int OS_W = $clog2(OVS);
  localparam int CW   = DIV_W + 1;
  localparam div_word_t         RST_DIV  = calc_div(longint'(SYS_CLK), longint'(BAUD_RATE),
                                                    longint'(OVS));
  localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RST_DIV.int_part);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RST_DIV.frac_part);

  logic [DIV_W-1:0]  cyc_cnt;
  logic [OS_W-1:0]   os_cnt;
  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic [DIV_W-1:0]  shd_int;
  logic [FRAC_W-1:0] shd_frac;
  logic              pending;
  logic              rx_q;
  logic              mid_q;
  logic              tx_q;
  logic              ext;
  logic              tc;
  logic              apply_now;
  logic [DIV_W-1:0]  int_eff;
  logic [CW-1:0]     last_cnt;

  uart_frac_accum #(.FRAC_W(FRAC_W)) u_frac (
    .clk   (clk),
    .rst   (rst),
    .step  (tc && !bus.resync),
    .clear (bus.resync),
    .frac  (act_frac),
    .ext   (ext)
  );

  // Terminal-count detect; integer parts 0 and 1 both mean a 1-clock base period
  always_comb begin
    int_eff   = (act_int < DIV_W'(2)) ? DIV_W'(1) : act_int;
    last_cnt  = {1'b0, int_eff} - CW'(1) + CW'(ext);
    tc        = bus.baud_en && ({1'b0, cyc_cnt} == last_cnt);
    apply_now = (tc && !bus.resync) || !bus.baud_en;
  end

  // Cycle/oversample counters and registered tick outputs; resync wins over tc
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_cnt <= '0;
      os_cnt  <= '0;
      rx_q    <= 1'b0;
      mid_q   <= 1'b0;
      tx_q    <= 1'b0;
    end else begin
      rx_q  <= 1'b0;
      mid_q <= 1'b0;
      tx_q  <= 1'b0;
      if (bus.resync) begin
        cyc_cnt <= '0;
        os_cnt  <= '0;
      end else if (tc) begin
        cyc_cnt <= '0;
        os_cnt  <= os_cnt + OS_W'(1);
        rx_q    <= 1'b1;
        mid_q   <= (os_cnt == OS_W'(OVS / 2 - 1));
        tx_q    <= (os_cnt == OS_W'(OVS - 1));
      end else if (bus.baud_en) begin
        cyc_cnt <= cyc_cnt + DIV_W'(1);
      end
    end
  end

  // Divisor shadow: loads take effect at a period boundary, or at once while idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      act_int  <= RST_INT;
      act_frac <= RST_FRAC;
      shd_int  <= '0;
      shd_frac <= '0;
      pending  <= 1'b0;
    end else begin
      if (bus.div_load) begin
        shd_int  <= bus.div_int;
        shd_frac <= bus.div_frac;
      end
      if (apply_now && bus.div_load) begin
        act_int  <= bus.div_int;
        act_frac <= bus.div_frac;
        pending  <= 1'b0;
      end else if (apply_now && pending) begin
        act_int  <= shd_int;
        act_frac <= shd_frac;
        pending  <= 1'b0;
      end else if (bus.div_load) begin
        pending  <= 1'b1;
      end
    end
  end

  assign bus.rx_tick    = rx_q;
  assign bus.mid_tick   = mid_q;
  assign bus.tx_tick    = tx_q;
  assign bus.div_active = {act_int, act_frac};
endmodule
